// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and ex_hazard_ctrl (slave).
// HAZ_PERF_CNT_EN adds the stall_cnt/flush_cnt performance counters.
interface ex_hazard_ctrl_if #(
    parameter int REG_AW = 4
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_hlt;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_mem_read;
    logic [REG_AW-1:0] mem_dst;
    logic [REG_AW-1:0] wb_dst;
    logic              mem_we;
    logic              wb_we;
    logic              br_taken;
    logic              mem_busy;

    logic              src0_fwd;
    logic              src1_fwd;
    logic              src0_memex_fwd;
    logic              src1_memex_fwd;
    logic              stall;
    logic              flush_ifid;
    logic              flush_idex;
    logic              halted;
    logic [1:0]        state_dbg;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    // No valid/ready handshake here: every signal is a per-cycle level sampled
    // by the pipeline registers on the rising clock edge.
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_hlt,
        output ex_rs, ex_rt, ex_dst, ex_mem_read,
        output mem_dst, wb_dst, mem_we, wb_we, br_taken, mem_busy,
`ifdef HAZ_PERF_CNT_EN
        input  stall_cnt, flush_cnt,
`endif
        input  src0_fwd, src1_fwd, src0_memex_fwd, src1_memex_fwd,
        input  stall, flush_ifid, flush_idex, halted, state_dbg
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_hlt,
        input  ex_rs, ex_rt, ex_dst, ex_mem_read,
        input  mem_dst, wb_dst, mem_we, wb_we, br_taken, mem_busy,
`ifdef HAZ_PERF_CNT_EN
        output stall_cnt, flush_cnt,
`endif
        output src0_fwd, src1_fwd, src0_memex_fwd, src1_memex_fwd,
        output stall, flush_ifid, flush_idex, halted, state_dbg
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard scheduler: operand forwarding, load-use stall, branch flush, HLT drain.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush event counters.
module ex_hazard_ctrl #(
    parameter int REG_AW    = 4,
    parameter int DRAIN_CYC = 3
) (
    input logic          clk,
    input logic          rst,
    ex_hazard_ctrl_if.slave hz
);
    localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lu_q, lu_d;
    logic            lu_raw, lu_stall;
    logic            stall_c, flush_ifid_c, flush_idex_c;
    logic            s0_mem, s0_wb, s1_mem, s1_wb;

    // R0 is hardwired zero, so a zero source never takes a forwarded value.
    assign s0_mem = hz.mem_we && (hz.mem_dst == hz.ex_rs) && (hz.ex_rs != '0);
    assign s0_wb  = hz.wb_we  && (hz.wb_dst  == hz.ex_rs) && (hz.ex_rs != '0);
    assign s1_mem = hz.mem_we && (hz.mem_dst == hz.ex_rt) && (hz.ex_rt != '0);
    assign s1_wb  = hz.wb_we  && (hz.wb_dst  == hz.ex_rt) && (hz.ex_rt != '0);

    assign hz.src0_fwd       = s0_mem | s0_wb;
    assign hz.src0_memex_fwd = s0_mem;
    assign hz.src1_fwd       = s1_mem | s1_wb;
    assign hz.src1_memex_fwd = s1_mem;

    // lu_q blocks a second back-to-back load-use stall: the bubble is already in EX.
    assign lu_raw = hz.ex_mem_read && (hz.ex_dst != '0) && !lu_q &&
                    ((hz.id_uses_rs && (hz.id_rs == hz.ex_dst)) ||
                     (hz.id_uses_rt && (hz.id_rt == hz.ex_dst)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            lu_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lu_q    <= lu_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lu_stall     = 1'b0;
        stall_c      = 1'b0;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;
        if (hz.mem_busy) begin
            stall_c = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (hz.br_taken) begin
                        flush_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                    end else if (lu_raw) begin
                        lu_stall     = 1'b1;
                        stall_c      = 1'b1;
                        flush_idex_c = 1'b1;
                    end else if (hz.id_hlt) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CW'(DRAIN_CYC - 1);
                    end
                end
                ST_DRAIN: begin
                    // An older taken branch in EX squashes the HLT behind it.
                    if (hz.br_taken) begin
                        flush_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                        state_d      = ST_RUN;
                        cnt_d        = '0;
                    end else begin
                        stall_c      = 1'b1;
                        flush_ifid_c = 1'b1;
                        if (cnt_q == '0) state_d = ST_HALT;
                        else             cnt_d   = cnt_q - CW'(1);
                    end
                end
                ST_HALT: begin
                    stall_c      = 1'b1;
                    flush_ifid_c = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
        lu_d = hz.mem_busy ? lu_q : lu_stall;
    end

    assign hz.stall      = stall_c      & ~rst;
    assign hz.flush_ifid = flush_ifid_c & ~rst;
    assign hz.flush_idex = flush_idex_c & ~rst;
    assign hz.halted     = (state_q == ST_HALT);
    assign hz.state_dbg  = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != ST_HALT) begin
            if ((hz.mem_busy || lu_stall) && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (hz.br_taken && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif
endmodule
